// File: rtl/spi_sram_ctrl_if.sv
// spi_sram_ctrl_if: request/response bus and SRAM pins for spi_sram_ctrl
interface spi_sram_ctrl_if #(parameter int ADDR_W = 17);
  logic req, we;
  logic [2:0] funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rdata;
  logic busy, valid, so, si, sclk, sram_ce;
  modport master (output req, we, funct3, addr, wdata, so, input rdata, busy, valid, si, sclk, sram_ce);
  modport slave (input req, we, funct3, addr, wdata, so, output rdata, busy, valid, si, sclk, sram_ce);
endinterface

// File: rtl/spi_sram_ctrl.sv
// spi_sram_ctrl: one load/store as a mode-0 SPI SRAM READ/WRITE frame.
// SRAM_MODE_INIT_EN: send WRMR 0x40 after reset before accepting requests.
module spi_sram_ctrl #(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W = 17
) (
  input logic clk,
  input logic reset,
  spi_sram_ctrl_if.slave bus
);
`ifdef SRAM_MODE_INIT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, INIT} state_t;
  localparam state_t RST_S = INIT;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam state_t RST_S = IDLE;
`endif
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  state_t state_q, state_d;
  logic [DW-1:0] div_q;
  logic [6:0] bit_q, nb_q;
  logic sclk_q, we_q, init_q;
  logic [2:0] f3_q;
  logic [63:0] sh_q;
  logic [31:0] rx_q, rdata_q, ld, w;
  logic [15:0] h;
  logic [7:0] b;
  logic tick, last, accept;
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign last = state_q == SHIFT && tick && sclk_q && bit_q == nb_q - 7'd1;
  assign accept = state_q == IDLE && bus.req;
  // rx_q holds bytes in arrival order; byte-swap to little-endian
  assign b = rx_q[7:0];
  assign h = {rx_q[7:0], rx_q[15:8]};
  assign w = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
  assign ld = f3_q[1] ? w :
              f3_q[0] ? {{16{h[15] & ~f3_q[2]}}, h} : {{24{b[7] & ~f3_q[2]}}, b};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= RST_S;
    else state_q <= state_d;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = bus.req ? SHIFT : IDLE;
      SHIFT: state_d = last ? DONE : SHIFT;
`ifdef SRAM_MODE_INIT_EN
      INIT: state_d = SHIFT;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.sram_ce = state_q != SHIFT;
    bus.sclk = sclk_q;
    bus.si = state_q == SHIFT && sh_q[63];
    bus.valid = state_q == DONE && !init_q;
    bus.rdata = rdata_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_q <= '0;
      bit_q <= '0;
      nb_q <= '0;
      sclk_q <= 1'b0;
      we_q <= 1'b0;
      init_q <= 1'b0;
      f3_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q != SHIFT) begin
        div_q <= '0;
        bit_q <= '0;
        sclk_q <= 1'b0;
      end else if (tick) begin
        div_q <= '0;
        sclk_q <= !sclk_q;
        if (!sclk_q) rx_q <= {rx_q[30:0], bus.so};
        else begin
          sh_q <= sh_q << 1;
          bit_q <= bit_q + 7'd1;
        end
      end else div_q <= div_q + 1'b1;
      if (accept) begin
        we_q <= bus.we;
        f3_q <= bus.funct3;
        init_q <= 1'b0;
        nb_q <= bus.funct3[1:0] == 2'b00 ? 7'd40 : bus.funct3[1:0] == 2'b01 ? 7'd48 : 7'd64;
        sh_q <= {bus.we ? 8'h02 : 8'h03, 24'(bus.addr),
                 bus.we ? {bus.wdata[7:0], bus.wdata[15:8], bus.wdata[23:16], bus.wdata[31:24]} : 32'h0};
      end
`ifdef SRAM_MODE_INIT_EN
      if (state_q == INIT) begin
        init_q <= 1'b1;
        nb_q <= 7'd16;
        sh_q <= {16'h0140, 48'h0};
      end
`endif
      if (last && !we_q && !init_q) rdata_q <= ld;
    end
endmodule

// File: tb/tb_spi_sram_ctrl.sv
// tb_spi_sram_ctrl: directed vectors against two DUTs (H=1, H=3) with SPI SRAM models
module tb_spi_sram_ctrl;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic req[2], we[2];
  logic [2:0] f3[2];
  logic [16:0] addr[2];
  logic [31:0] wdata[2], rdata_w[2], hdr_a[2];
  logic valid_w[2], busy_w[2], ce_w[2], sclk_w[2], si_w[2];
  int nvalid[2], celow[2], schi[2], viol[2];
  int nvec = 0, nerr = 0;
  for (genvar g = 0; g < 2; g++) begin : u
    spi_sram_ctrl_if #(.ADDR_W(17)) bus();
    spi_sram_ctrl #(.CLK_DIV(g == 0 ? 1 : 3), .ADDR_W(17)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    logic [7:0] mem [0:131071];
    logic [7:0] sr, cmd, mode;
    logic [23:0] base;
    logic so_q = 0, psclk = 0, psi = 0;
    int cnt = 0;
    assign bus.req = req[g];
    assign bus.we = we[g];
    assign bus.funct3 = f3[g];
    assign bus.addr = addr[g];
    assign bus.wdata = wdata[g];
    assign bus.so = so_q;
    assign rdata_w[g] = bus.rdata;
    assign valid_w[g] = bus.valid;
    assign busy_w[g] = bus.busy;
    assign ce_w[g] = bus.sram_ce;
    assign sclk_w[g] = bus.sclk;
    assign si_w[g] = bus.si;
    initial begin
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      mem[17'h10] = 8'h11; mem[17'h11] = 8'h22; mem[17'h12] = 8'h33; mem[17'h13] = 8'h44;
      mem[17'h20] = 8'h80; mem[17'h30] = 8'hFE; mem[17'h31] = 8'hFF;
      mem[17'h1FFFE] = 8'h55; mem[17'h1FFFF] = 8'h66; mem[17'h0] = 8'h77;
    end
    always @(posedge bus.sclk or posedge bus.sram_ce)
      if (bus.sram_ce) cnt = 0;
      else begin
        if (cnt == 0) hdr_a[g] = 32'h0;
        sr = {sr[6:0], bus.si};
        cnt++;
        if (cnt <= 32) hdr_a[g] = {hdr_a[g][30:0], bus.si};
        if (cnt == 8) cmd = sr;
        if (cnt == 32) base = hdr_a[g][23:0];
        if (cmd == 8'h01 && cnt == 16) mode = sr;
        if (cmd == 8'h02 && cnt > 32 && cnt % 8 == 0) mem[17'(base + 24'((cnt - 40) / 8))] = sr;
      end
    always @(negedge bus.sclk)
      if (!bus.sram_ce && cmd == 8'h03 && cnt >= 32)
        so_q = mem[17'(base + 24'((cnt - 32) / 8))][7 - (cnt - 32) % 8];
    always @(negedge clk) begin
      if (bus.valid) nvalid[g]++;
      if (!bus.sram_ce) celow[g]++;
      if (bus.sclk) schi[g]++;
      if (psclk && bus.sclk && bus.si != psi) viol[g]++;
      psclk = bus.sclk;
      psi = bus.si;
    end
  end
  typedef struct {
    logic w; logic [2:0] f; logic [16:0] a; logic [31:0] d;
    logic [31:0] rd; int lat; logic [31:0] hdr;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic xact(input int i, input logic w, input logic [2:0] f, input logic [16:0] a,
                      input logic [31:0] d, output int lat);
    @(negedge clk);
    celow[i] = 0; schi[i] = 0; viol[i] = 0;
    we[i] = w; f3[i] = f; addr[i] = a; wdata[i] = d; req[i] = 1;
    @(negedge clk);
    req[i] = 0;
    lat = 1;
    while (!valid_w[i] && lat < 2000) begin @(negedge clk); lat++; end
    chk("busy_at_valid", 32'(busy_w[i]), 32'd1);
    @(negedge clk);
    chk("busy_after_valid", 32'(busy_w[i]), 32'd0);
  endtask
  task automatic release_reset;
    int n;
    repeat (2) @(negedge clk);
    reset = 1;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 500) begin
      if (busy_w[0]) n++;
      @(negedge clk);
    end
`ifdef SRAM_MODE_INIT_EN
    chk("init_busy_cycles", n, 34);
    chk("init_frame", {16'h0, hdr_a[0][15:0]}, 32'h0140);
    chk("init_mode", {24'h0, u[0].mode}, 32'h40);
`endif
  endtask
  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin req[i] = 0; we[i] = 0; f3[i] = 0; addr[i] = 0; wdata[i] = 0; end
    v[0]  = '{0, 3'b010, 17'h10,    32'h0,        32'h44332211, 129, 32'h03000010};
    v[1]  = '{0, 3'b000, 17'h20,    32'h0,        32'hFFFFFF80,  81, 32'h03000020};
    v[2]  = '{0, 3'b100, 17'h20,    32'h0,        32'h00000080,  81, 32'h03000020};
    v[3]  = '{0, 3'b001, 17'h30,    32'h0,        32'hFFFFFFFE,  97, 32'h03000030};
    v[4]  = '{0, 3'b101, 17'h30,    32'h0,        32'h0000FFFE,  97, 32'h03000030};
    v[5]  = '{1, 3'b000, 17'h1FFFF, 32'hAABBCCDD, 32'h0000FFFE,  81, 32'h0201FFFF};
    v[6]  = '{1, 3'b010, 17'h40,    32'h12345678, 32'h0000FFFE, 129, 32'h02000040};
    v[7]  = '{0, 3'b010, 17'h40,    32'h0,        32'h12345678, 129, 32'h03000040};
    v[8]  = '{1, 3'b001, 17'h50,    32'h0000BEEF, 32'h12345678,  97, 32'h02000050};
    v[9]  = '{0, 3'b001, 17'h50,    32'h0,        32'hFFFFBEEF,  97, 32'h03000050};
    v[10] = '{0, 3'b000, 17'h51,    32'h0,        32'hFFFFFFBE,  81, 32'h03000051};
    v[11] = '{0, 3'b011, 17'h10,    32'h0,        32'h44332211, 129, 32'h03000010};
    repeat (2) @(negedge clk);
    chk("rst_si", 32'(si_w[0]), 32'd0);
    chk("rst_ce", 32'(ce_w[0]), 32'd1);
    chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_valid", 32'(valid_w[0]), 32'd0);
    chk("rst_rdata", rdata_w[0], 32'h0);
`ifdef SRAM_MODE_INIT_EN
    chk("rst_busy", 32'(busy_w[0]), 32'd1);
`else
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
`endif
    release_reset();
    for (int i = 0; i < 12; i++) begin
      xact(0, v[i].w, v[i].f, v[i].a, v[i].d, lat);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_rdata", i), rdata_w[0], v[i].rd);
      chk($sformatf("v%0d_frame", i), hdr_a[0], v[i].hdr);
      chk($sformatf("v%0d_ce_low", i), celow[0], v[i].lat - 1);
    end
    chk("sb_byte", {24'h0, u[0].mem[17'h1FFFF]}, 32'hDD);
    chk("sb_below", {24'h0, u[0].mem[17'h1FFFE]}, 32'h55);
    chk("sb_wrap", {24'h0, u[0].mem[17'h0]}, 32'h77);
    chk("sw_byte3", {24'h0, u[0].mem[17'h43]}, 32'h12);
    @(negedge clk);
    nvalid[0] = 0;
    we[0] = 0; f3[0] = 3'b000; addr[0] = 17'h20; req[0] = 1;
    @(negedge clk); req[0] = 0;
    repeat (10) @(negedge clk);
    f3[0] = 3'b010; addr[0] = 17'h10; req[0] = 1;
    @(negedge clk); req[0] = 0;
    repeat (300) @(negedge clk);
    chk("busy_req_valids", nvalid[0], 1);
    chk("busy_req_rdata", rdata_w[0], 32'hFFFFFF80);
    xact(1, 0, 3'b001, 17'h30, 32'h0, lat);
    chk("h3_latency", lat, 289);
    chk("h3_rdata", rdata_w[1], 32'hFFFFFFFE);
    chk("h3_ce_low", celow[1], 288);
    chk("h3_sclk_high", schi[1], 144);
    chk("h3_si_while_high", viol[1], 0);
    @(negedge clk);
    nvalid[0] = 0;
    we[0] = 0; f3[0] = 3'b010; addr[0] = 17'h10; req[0] = 1;
    @(negedge clk); req[0] = 0;
    repeat (20) @(negedge clk);
    chk("mid_ce_before", 32'(ce_w[0]), 32'd0);
    reset = 0;
    #1;
    chk("mid_rst_ce", 32'(ce_w[0]), 32'd1);
    chk("mid_rst_sclk", 32'(sclk_w[0]), 32'd0);
    chk("mid_rst_si", 32'(si_w[0]), 32'd0);
    chk("mid_rst_rdata", rdata_w[0], 32'h0);
    release_reset();
    repeat (200) @(negedge clk);
    chk("mid_rst_no_valid", nvalid[0], 0);
    xact(0, 0, 3'b000, 17'h20, 32'h0, lat);
    chk("post_rst_latency", lat, 81);
    chk("post_rst_rdata", rdata_w[0], 32'hFFFFFF80);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/spi_sram_ctrl.md
# spi_sram_ctrl

Serial back end for the data/instruction memory path: converts one word/half/byte load or store request into a complete SPI mode-0 transaction on an external 23LC1024-class SPI SRAM (READ 0x03 / WRITE 0x02, 24-bit address, sequential mode). It sits directly downstream of the memory address decoder, which drives it whenever an access falls in the SRAM window. It owns the chip pins `so`/`si`/`sclk`/`sram_ce`. Load data is returned little-endian and sign/zero-extended per funct3, ready for register writeback.

## Interface
- `CLK_DIV`, 1: system clocks per sclk half-period (H); sclk = clk/(2·H); must be ≥1.
- `ADDR_W`, 17: significant SRAM address bits; zero-padded to 24 on the wire.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request, sampled only while `busy`=0.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `funct3`  in  3  RV32 size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  ADDR_W  byte address of first byte.
- `wdata`  in  32  store data; byte at `addr` is wdata[7:0].
- `rdata`  out  32  extended load result, held until the next read completes.
- `busy`  out  1  high while a transaction (or init) is in progress.
- `valid`  out  1  one-cycle pulse at transaction end (reads and writes).
- `so`  in  1  SRAM serial out.
- `si`  out  1  SRAM serial in.
- `sclk`  out  1  SPI clock, idle low.
- `sram_ce`  out  1  SRAM chip enable, active low.

## Operation
- States: INIT (macro only), IDLE, SHIFT, DONE.
- IDLE: `busy`=0, `sram_ce`=1, `sclk`=0. On `req`: latch `we`, `funct3`, `addr`, `wdata`; N = 1/2/4 from funct3[1:0] (11 treated as 4); B = 32 + 8·N; go SHIFT.
- SHIFT: `sram_ce`=0. Frame MSB-first: cmd byte, addr[23:0], then N data bytes in ascending address order, each byte MSB-first. Writes shift wdata bytes 0..N-1; reads drive `si`=0 during data bytes.
- Mode 0: `si` changes only when `sclk` is low; `so` registered on the clk edge where `sclk` rises. Read bytes assembled little-endian (first byte → bits 7:0).
- After bit B's high phase: `sclk`=0, go DONE. DONE (1 cycle): `sram_ce`=1, `valid`=1, `rdata` updated (reads only: LB/LH sign-extend, LBU/LHU zero-extend, LW raw); go IDLE.
- `req` while `busy`=1 is ignored, never queued. No alignment checks; sequential mode handles crossing byte boundaries.
- Outputs after reset: `sclk`=0, `si`=0, `sram_ce`=1, `valid`=0, `rdata`=0, `busy`=0 (1 if SRAM_MODE_INIT_EN).
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); partial transfer abandoned, `valid` not pulsed.

## Timing
- `req` accepted at edge k: `busy`=1 and `sram_ce`=0 from k+1; first `si` bit valid at k+1, `sclk` low.
- Each bit lasts 2·H cycles: H low, then H high.
- `valid` high in cycle k+1+2·H·B; `busy` falls the cycle after. Minimum `sram_ce` high time between transactions is 2 cycles (DONE + IDLE).
- Latency, H=1: LB/SB 81 cycles, LH/SH 97, LW/SW 129 (accept → `valid`).
- `rdata` stable from the `valid` cycle until the next read's DONE.

## Configuration
- `SRAM_MODE_INIT_EN` defined: after reset release, INIT sends WRMR (0x01) then mode byte 0x40 (sequential) as one 16-bit frame with the same mode-0 timing. `busy`=1 throughout; no `valid` pulse; enter IDLE after `sram_ce` rises. INIT lasts 1 + 32·H + 1 cycles.
- Undefined: no INIT state; IDLE immediately after reset. The SRAM's power-on sequential default is relied on.

## Test plan
- LW, H=1, addr=0x00010, SRAM model holding bytes 11 22 33 44 → `si` frame 0x03,0x00,0x00,0x10; `valid` at k+129; `rdata`=0x44332211; `sram_ce` low exactly 128 cycles.
- SB wdata=0xAABBCCDD, addr=0x1FFFF → frame 0x02,0x01,0xFF,0xFF,0xDD; `valid` at k+81; model byte 0x1FFFF = 0xDD, neighbouring bytes untouched.
- LB and LBU at a byte holding 0x80 → `rdata` 0xFFFFFF80 and 0x00000080; LH at 0xFE 0xFF → 0xFFFFFFFE.
- CLK_DIV=3, LH → `sclk` period 6 cycles; `valid` at k+1+6·48 = k+289; no `si` change while `sclk` high.
- Second `req` pulsed during `busy` → ignored; exactly one `valid`. Reset dropped mid-SHIFT → `sram_ce`=1, `sclk`=0 same cycle; no `valid`; next request completes normally.
- With SRAM_MODE_INIT_EN, H=1: `si` frame 0x01,0x40 after reset; `busy` high 34 cycles; `req` during INIT ignored.
